// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequential integer multiply/divide unit.
// Multiplication is a radix-2 shift-add and division is a restoring radix-2
// divide. Both work on operand magnitudes, one bit per CALC cycle, and the
// sign is fixed up once at completion. Divide-by-zero, signed overflow and
// illegal subcodes skip CALC and go straight to DONE.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [6:0]      req_subcode,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            flush,
   output logic            busy,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_illegal
);

   // FSM encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Supported ALU subcodes
   localparam logic [6:0] IOP_MUL    = 7'h04;
   localparam logic [6:0] IOP_MULH   = 7'h05;
   localparam logic [6:0] IOP_MULHSU = 7'h06;
   localparam logic [6:0] IOP_MULHU  = 7'h07;
   localparam logic [6:0] IOP_DIV    = 7'h08;
   localparam logic [6:0] IOP_DIVU   = 7'h09;
   localparam logic [6:0] IOP_REM    = 7'h0A;
   localparam logic [6:0] IOP_REMU   = 7'h0B;

   localparam int               CNT_W     = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

   // Architectural state
   logic [1:0]       state_reg;
   logic [6:0]       op_reg;        // latched subcode of the operation in flight
   logic             neg_reg;       // final result must be negated
   logic [CNT_W-1:0] cnt_reg;       // iteration counter within CALC
   logic [XLEN-1:0]  acc_hi_reg;    // product high half / partial remainder
   logic [XLEN-1:0]  acc_lo_reg;    // multiplier bits / dividend-quotient shifter
   logic [XLEN-1:0]  opnd_reg;      // multiplicand or divisor magnitude
   logic [XLEN-1:0]  result_reg;
   logic             illegal_reg;

   // Request decode
   logic            req_legal;
   logic            req_is_div;
   logic            req_is_rem;
   logic            a_signed;
   logic            b_signed;
   logic            a_neg;
   logic            b_neg;
   logic            req_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            req_bypass;
   logic [XLEN-1:0] bypass_result;

   // Iteration datapath
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_borrow;
   logic [XLEN-1:0] div_diff;
   logic [XLEN-1:0] step_hi;
   logic [XLEN-1:0] step_lo;

   // Completion fix-up
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] product_signed;
   logic [XLEN-1:0]   quot_signed;
   logic [XLEN-1:0]   rem_signed;
   logic [XLEN-1:0]   final_result;

   // Decode the offered request: legality, operand signedness and magnitudes,
   // result sign, and the single-cycle bypass cases of the divider.
   always_comb begin
      req_legal  = 1'b0;
      a_signed   = 1'b0;
      b_signed   = 1'b0;
      case (req_subcode)
         IOP_MUL:    req_legal = 1'b1;
         IOP_MULH:   begin req_legal = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         IOP_MULHSU: begin req_legal = 1'b1; a_signed = 1'b1; end
         IOP_MULHU:  req_legal = 1'b1;
         IOP_DIV:    begin req_legal = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         IOP_DIVU:   req_legal = 1'b1;
         IOP_REM:    begin req_legal = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         IOP_REMU:   req_legal = 1'b1;
         default:    req_legal = 1'b0;
      endcase
      req_is_div = req_subcode[3];
      req_is_rem = req_subcode[1];
      a_neg      = a_signed & req_a[XLEN-1];
      b_neg      = b_signed & req_b[XLEN-1];
      mag_a      = a_neg ? -req_a : req_a;
      mag_b      = b_neg ? -req_b : req_b;
      // Remainder follows the dividend sign; everything else is sign(a)^sign(b).
      req_neg    = (req_is_div && req_is_rem) ? a_neg : (a_neg ^ b_neg);

      req_bypass    = 1'b0;
      bypass_result = '0;
      if (req_is_div) begin
         if (req_b == '0) begin
            req_bypass    = 1'b1;
            bypass_result = req_is_rem ? req_a : '1;
         end else if (a_signed && (req_a == MIN_NEG) && (req_b == '1)) begin
            req_bypass    = 1'b1;
            bypass_result = req_is_rem ? '0 : MIN_NEG;
         end
      end
   end

   // One shift-add or one restoring-divide step per CALC cycle.
   always_comb begin
      mul_sum    = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
      div_shift  = {acc_hi_reg, acc_lo_reg[XLEN-1]};
      div_borrow = div_shift < {1'b0, opnd_reg};
      // When there is no borrow the difference is below the divisor, so the
      // low XLEN bits carry the whole partial remainder.
      div_diff   = div_shift[XLEN-1:0] - opnd_reg;
      if (op_reg[3]) begin
         step_hi = div_borrow ? div_shift[XLEN-1:0] : div_diff;
         step_lo = {acc_lo_reg[XLEN-2:0], ~div_borrow};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
      end
   end

   // Apply the sign and select the result half from the final step's output.
   always_comb begin
      product        = {step_hi, step_lo};
      product_signed = neg_reg ? -product : product;
      quot_signed    = neg_reg ? -step_lo : step_lo;
      rem_signed     = neg_reg ? -step_hi : step_hi;
      if (op_reg[3]) begin
         final_result = op_reg[1] ? rem_signed : quot_signed;
      end else if (op_reg == IOP_MUL) begin
         final_result = product_signed[XLEN-1:0];
      end else begin
         final_result = product_signed[2*XLEN-1:XLEN];
      end
   end

   // Sequencer FSM and datapath registers; flush overrides accept and handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         op_reg      <= '0;
         neg_reg     <= 1'b0;
         cnt_reg     <= '0;
         acc_hi_reg  <= '0;
         acc_lo_reg  <= '0;
         opnd_reg    <= '0;
         result_reg  <= '0;
         illegal_reg <= 1'b0;
      end else if (flush) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  op_reg  <= req_subcode;
                  neg_reg <= req_neg;
                  cnt_reg <= '0;
                  if (!req_legal) begin
                     result_reg  <= '0;
                     illegal_reg <= 1'b1;
                     state_reg   <= S_DONE;
                  end else begin
                     illegal_reg <= 1'b0;
                     if (req_bypass) begin
                        result_reg <= bypass_result;
                        state_reg  <= S_DONE;
                     end else begin
                        acc_hi_reg <= '0;
                        acc_lo_reg <= req_is_div ? mag_a : mag_b;
                        opnd_reg   <= req_is_div ? mag_b : mag_a;
                        state_reg  <= S_CALC;
                     end
                  end
               end
            end
            S_CALC: begin
               acc_hi_reg <= step_hi;
               acc_lo_reg <= step_lo;
               cnt_reg    <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_ITER) begin
                  result_reg <= final_result;
                  state_reg  <= S_DONE;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (state_reg == S_IDLE);
   assign busy        = (state_reg == S_CALC);
   assign rsp_valid   = (state_reg == S_DONE);
   assign rsp_result  = result_reg;
   assign rsp_illegal = illegal_reg;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the operand and result width; only 32 is supported.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  sequencer can accept a request.
- req_subcode  input  7  ALU_SUBCODE value.
- req_a  input  XLEN  rs1 operand: multiplicand or dividend.
- req_b  input  XLEN  rs2 operand: multiplier or divisor.
- flush  input  1  synchronous abort of any operation in flight.
- busy  output  1  iteration in progress.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_result  output  XLEN  result value.
- rsp_illegal  output  1  unsupported subcode.

Function
REQ-003 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-004 req_ready SHALL be 1 only in IDLE, and busy SHALL be 1 only in CALC.
REQ-005 An accept SHALL occur when req_valid=1 and req_ready=1 on a clock edge; at that edge the subcode and operands SHALL be latched.
REQ-006 The supported subcodes SHALL be IOP_MUL (0x04), IOP_MULH (0x05), IOP_MULHSU (0x06), IOP_MULHU (0x07), IOP_DIV (0x08), IOP_DIVU (0x09), IOP_REM (0x0A) and IOP_REMU (0x0B); every other subcode, including the W forms with bit 6 set, SHALL be illegal.
REQ-007 On an illegal accept the block SHALL go from IDLE to DONE with rsp_result=0 and rsp_illegal=1, one cycle latency.
REQ-008 Multiplication SHALL use a radix-2 shift-add over the operand magnitudes, one bit per cycle for 32 CALC cycles, producing a 64-bit product.
- Signedness: MULH is signed x signed; MULHSU is signed a x unsigned b; MULHU and MUL are unsigned.
- The product SHALL be negated at completion when the result sign is negative.
REQ-009 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-010 Division SHALL use a restoring radix-2 algorithm over the magnitudes (signed for DIV and REM), one quotient bit per cycle for 32 CALC cycles.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
REQ-011 Divide-by-zero (b=0) SHALL bypass CALC with one cycle latency:
- DIV and DIVU return 0xFFFFFFFF.
- REM and REMU return a.
REQ-012 Signed overflow (DIV or REM with a=0x80000000, b=0xFFFFFFFF) SHALL bypass CALC with one cycle latency: DIV returns 0x80000000 and REM returns 0.
REQ-013 For a normal operation, rsp_valid SHALL first be high 33 cycles after the accept edge: 32 cycles in CALC, then DONE.
REQ-014 In DONE, rsp_valid SHALL be 1, and rsp_result and rsp_illegal SHALL stay stable until rsp_ready=1.
REQ-015 On the rsp handshake the block SHALL return to IDLE; a new request SHALL NOT be accepted on the same edge as the handshake.
REQ-016 flush=1 SHALL force IDLE on the next edge from any state and drop rsp_valid without a handshake.
- flush SHALL take priority over an accept and over a response handshake on the same edge.
REQ-017 rsp_illegal SHALL be cleared on every legal accept.

Reset
REQ-018 While rst_n=0 the block SHALL hold the following values, independent of clk:
- state = IDLE
- rsp_valid = 0
- rsp_result = 0
- rsp_illegal = 0
- busy = 0
- iteration counter = 0
- req_ready = 1
REQ-019 Asserting rst_n mid-CALC or in DONE SHALL abandon the operation; no response SHALL follow reset release.

Verification
REQ-020 MUL with a=7, b=0xFFFFFFFD -> rsp_result=0xFFFFFFEB, with rsp_valid rising exactly 33 cycles after the accept.
REQ-021 Operands a=b=0xFFFFFFFF -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF.
REQ-022 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-023 The following cases SHALL produce rsp_valid one cycle after the accept:
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- Subcode 0x44 (IOP_MULW) -> rsp_illegal=1, rsp_result=0.
REQ-024 With rsp_ready held at 0 for 5 cycles in DONE, the result SHALL stay stable and req_ready SHALL stay 0; after the handshake, req_ready=1 on the next cycle.
REQ-025 Abort cases:
- flush asserted on CALC cycle 10 -> IDLE next cycle, and no rsp_valid ever follows.
- rst_n pulsed low mid-CALC -> all outputs at reset values immediately, and a following MUL 3x4 returns 12.
